// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT front end: coefficient width, quant-entry
// width, block buffer states and the zigzag scan table.
package idct_pkg;

  localparam int ML_DEFAULT = 16;
  localparam int QW         = 8;
  localparam int NCOEF      = 64;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILL,
    BUF_FULL
  } buf_state_e;

  // ZZ[k] is the natural row-major position of the k-th coefficient in scan order.
  localparam logic [5:0] ZZ [NCOEF] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

endpackage

// File: rtl/dq_mul_sat.sv
// Dequantizer arithmetic: signed coefficient times unsigned quant entry,
// saturated back to the coefficient width.
module dq_mul_sat
  import idct_pkg::*;
#(
  parameter int ML = ML_DEFAULT
) (
  input  logic signed [ML-1:0] coef,
  input  logic        [QW-1:0] q,
  output logic signed [ML-1:0] result
);

  localparam int PW = ML + QW;

  logic signed [PW-1:0] prod;
  logic                 overflow;

  always_comb begin
    prod = $signed({{QW{coef[ML-1]}}, coef}) * $signed({{ML{1'b0}}, q});
    // The product fits in ML bits only when every bit above ML-2 copies the sign.
    overflow = !((&prod[PW-1:ML-1]) || !(|prod[PW-1:ML-1]));
    if (overflow) begin
      result = prod[PW-1] ? {1'b1, {(ML-1){1'b0}}} : {1'b0, {(ML-1){1'b1}}};
    end else begin
      result = prod[ML-1:0];
    end
  end

endmodule

// File: rtl/dezigzag_dequant.sv
// Collects zigzag-ordered quantized coefficients, dequantizes them and
// presents full natural-order blocks from a pair of ping-pong buffers.
module dezigzag_dequant
  import idct_pkg::*;
#(
  parameter int ML = ML_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [ML-1:0] in_coef,
  input  logic                 in_eob,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 qt_we,
  input  logic [5:0]           qt_addr,
  input  logic [QW-1:0]        qt_data,
  output logic [ML*64-1:0]     out_block,
  output logic                 out_valid,
  input  logic                 out_ready
);

  buf_state_e state_q [2];
  buf_state_e state_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [5:0] k_q, k_d;
  logic       in_ready_d, out_valid_d;

  logic [ML-1:0] mem    [2][NCOEF];
  logic [63:0]   mask_q [2];
  logic [QW-1:0] qt     [NCOEF];

  logic                 accept, rel, last;
  logic [5:0]           nat;
  logic signed [ML-1:0] dq;

  assign accept = in_valid && in_ready;
  assign rel    = out_valid && out_ready;
  assign last   = accept && ((k_q == 6'd63) || in_eob);
  assign nat    = ZZ[k_q];

  dq_mul_sat #(.ML(ML)) u_dq_mul_sat (
    .coef   (in_coef),
    .q      (qt[nat]),
    .result (dq)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '{BUF_EMPTY, BUF_EMPTY};
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      k_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      k_q       <= k_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next state. An accept and a release never hit the same buffer: accepts
  // need a non-FULL buffer, releases a FULL one.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    k_d      = k_q;
    if (accept) begin
      state_d[wr_ptr_q] = last ? BUF_FULL : BUF_FILL;
      if (last) begin
        k_d      = '0;
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        k_d = k_q + 6'd1;
      end
    end
    if (rel) begin
      state_d[rd_ptr_q] = BUF_EMPTY;
      rd_ptr_d          = ~rd_ptr_q;
    end
  end

  // Outputs: handshake flags are registered from the next state; the block
  // view masks out positions not written since the buffer was last released.
  always_comb begin
    in_ready_d  = (state_d[wr_ptr_d] != BUF_FULL);
    out_valid_d = (state_d[rd_ptr_d] == BUF_FULL);
    for (int n = 0; n < NCOEF; n++) begin
      out_block[n*ML +: ML] = mask_q[rd_ptr_q][n] ? mem[rd_ptr_q][n] : '0;
    end
  end

  // NOTE: coefficient storage has no reset; the written mask decides what is visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q][nat] <= dq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '{default: '0};
    end else begin
      if (accept) begin
        mask_q[wr_ptr_q][nat] <= 1'b1;
      end
      if (rel) begin
        mask_q[rd_ptr_q] <= '0;
      end
    end
  end

  // Quant table; a same-cycle accept still reads the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        qt[i] <= QW'(1);
      end
    end else if (qt_we) begin
      qt[qt_addr] <= qt_data;
    end
  end

endmodule

// File: tb/tb_dezigzag_dequant.sv
// Directed bench for dezigzag_dequant with an abstract block-queue model
// compared against the DUT on every cycle out of reset.
module tb_dezigzag_dequant;

  typedef int blk_t [64];

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] in_coef = '0;
  logic               in_eob = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               qt_we = 1'b0;
  logic [5:0]         qt_addr = '0;
  logic [7:0]         qt_data = '0;
  logic [1023:0]      out_block;
  logic               out_valid;
  logic               out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  dezigzag_dequant #(.ML(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_coef   (in_coef),
    .in_eob    (in_eob),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .qt_we     (qt_we),
    .qt_addr   (qt_addr),
    .qt_data   (qt_data),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int   zz_m [64];
  int   qt_m [64];
  blk_t mq [$];
  blk_t cur;
  int   mk;
  bit   m_in_ready, m_out_valid;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Zigzag order generated by walking anti-diagonals, alternating direction.
  initial begin
    int idx;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_m[idx] = r * 8 + (s - r); idx++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_m[idx] = r * 8 + (s - r); idx++; end
      end
    end
  end

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      foreach (cur[i]) cur[i] = 0;
      foreach (qt_m[i]) qt_m[i] = 1;
      mk = 0;
      m_in_ready = 1'b1;
      m_out_valid = 1'b0;
    end else begin
      bit acc, rl;
      acc = in_valid && m_in_ready;
      rl  = m_out_valid && out_ready;
      if (rl) void'(mq.pop_front());
      if (acc) begin
        int n;
        n = zz_m[mk];
        cur[n] = sat16(int'(in_coef) * qt_m[n]);
        if (mk == 63 || in_eob) begin
          mq.push_back(cur);
          foreach (cur[i]) cur[i] = 0;
          mk = 0;
        end else begin
          mk++;
        end
      end
      if (qt_we) qt_m[qt_addr] = int'(qt_data);
      m_in_ready  = (mq.size() < 2);
      m_out_valid = (mq.size() > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      n_checks++;
      if (in_ready !== m_in_ready) begin
        n_errors++;
        $display("FAIL in_ready cyc %0d got %b expected %b", cyc, in_ready, m_in_ready);
      end
      n_checks++;
      if (out_valid !== m_out_valid) begin
        n_errors++;
        $display("FAIL out_valid cyc %0d got %b expected %b", cyc, out_valid, m_out_valid);
      end
      if (m_out_valid && mq.size() > 0) begin
        blk_t f;
        int   bad;
        f = mq[0];
        bad = -1;
        for (int n = 63; n >= 0; n--) begin
          if (out_block[n*16 +: 16] !== 16'(f[n])) bad = n;
        end
        n_checks++;
        if (bad >= 0) begin
          n_errors++;
          $display("FAIL block cyc %0d element %0d got %0d expected %0d", cyc, bad,
                   $signed(out_block[bad*16 +: 16]), f[bad]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int elem(input int n);
    return int'($signed(out_block[n*16 +: 16]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int c, input logic e);
    bit acc;
    int guard;
    in_coef  = 16'(c);
    in_eob   = e;
    in_valid = 1'b1;
    guard    = 0;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 2000);
    if (!acc) check("send_timeout", 0, 1);
    in_eob = 1'b0;
  endtask

  task automatic release_block();
    bit acc;
    int guard;
    out_ready = 1'b1;
    guard     = 0;
    do begin
      acc = out_valid;
      tick();
      guard++;
    end while (!acc && guard < 2000);
    if (!acc) check("release_timeout", 0, 1);
    out_ready = 1'b0;
  endtask

  task automatic qt_write(input int a, input int d);
    qt_we = 1'b1; qt_addr = 6'(a); qt_data = 8'(d);
    tick();
    qt_we = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int got1 [3];
    int captured, nz, t0;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);

    // Full block of coef = k with unit scale.
    for (int k = 0; k < 64; k++) begin
      send(k, 1'b0);
      if (k == 62) check("t1_valid_before_last", int'(out_valid), 0);
    end
    in_valid = 1'b0;
    check("t1_valid_after_last", int'(out_valid), 1);
    check("t1_elem1", elem(1), 1);
    check("t1_elem8", elem(8), 2);
    check("t1_elem16", elem(16), 3);
    check("t1_elem63", elem(63), 63);
    release_block();

    // Single coefficient with eob; a stray eob without valid must be ignored.
    qt_write(0, 16);
    in_eob = 1'b1;
    tick(); tick();
    in_eob = 1'b0;
    check("t2_no_spurious_block", int'(out_valid), 0);
    send(100, 1'b1);
    in_valid = 1'b0;
    check("t2_valid", int'(out_valid), 1);
    check("t2_elem0", elem(0), 1600);
    nz = 0;
    for (int n = 1; n < 64; n++) if (elem(n) != 0) nz++;
    check("t2_zero_count", nz, 0);
    release_block();

    // Saturation at both rails and an in-range large product.
    qt_write(0, 2);
    send(32767, 1'b1); in_valid = 1'b0;
    check("t3_sat_pos", elem(0), 32767);
    release_block();
    qt_write(0, 255);
    send(-300, 1'b1); in_valid = 1'b0;
    check("t3_sat_neg", elem(0), -32768);
    release_block();
    send(100, 1'b1); in_valid = 1'b0;
    check("t3_no_sat", elem(0), 25500);
    release_block();

    // Backpressure: two blocks fill both buffers, a third waits.
    for (int b = 1; b <= 2; b++)
      for (int k = 0; k < 64; k++) send(b * 100 + k, 1'b0);
    in_valid = 1'b0;
    check("t4_in_ready_low", int'(in_ready), 0);
    check("t4_out_valid", int'(out_valid), 1);
    captured = 0;
    fork
      begin
        for (int k = 0; k < 64; k++) send(300 + k, 1'b0);
        in_valid = 1'b0;
      end
      begin
        int guard;
        repeat (4) tick();
        out_ready = 1'b1;
        guard = 0;
        while (captured < 3 && guard < 2000) begin
          if (out_valid) begin
            got1[captured] = elem(1);
            captured++;
          end
          tick();
          guard++;
        end
        out_ready = 1'b0;
      end
    join
    check("t4_blocks_out", captured, 3);
    check("t4_block1_elem1", got1[0], 101);
    check("t4_block2_elem1", got1[1], 201);
    check("t4_block3_elem1", got1[2], 301);

    // Throughput with out_ready held high, then back-to-back eob blocks
    // so completion and release coincide.
    qt_write(0, 1);
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 192; i++) send(i - 96, 1'b0);
    for (int i = 0; i < 4; i++) send(i + 7, 1'b1);
    in_valid = 1'b0;
    check("t5_throughput_cycles", cyc - t0, 196);
    repeat (4) tick();
    check("t5_drained", int'(out_valid), 0);

    // Reset mid-block.
    qt_write(0, 200);
    for (int k = 0; k < 30; k++) send(k + 1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b0;
    tick();
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_in_ready", int'(in_ready), 1);
    send(5, 1'b1); in_valid = 1'b0;
    check("t6_elem0", elem(0), 5);
    check("t6_elem1", elem(1), 0);
    release_block();

    // Quant write coinciding with the k=0 accept.
    qt_we = 1'b1; qt_addr = 6'd0; qt_data = 8'd7;
    send(9, 1'b1);
    qt_we = 1'b0;
    in_valid = 1'b0;
    check("t7_old_scale", elem(0), 9);
    release_block();
    send(9, 1'b1); in_valid = 1'b0;
    check("t7_new_scale", elem(0), 63);
    release_block();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dezigzag_dequant.md
DEZIGZAG_DEQUANT -- requirements
Module: dezigzag_dequant

Interface
REQ-001 SHALL have parameter ML, default 16, the coefficient word width matching the IDCT block input.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port in_coef, input, ML, signed quantized coefficient, arriving in zigzag scan order.
REQ-005 SHALL have port in_eob, input, 1, marking the current coefficient as the last non-zero coefficient of the block.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1) forming the coefficient handshake.
REQ-007 SHALL have ports qt_we (input, 1), qt_addr (input, 6) and qt_data (input, 8) for quant table writes; qt_data is unsigned and qt_addr is the natural row-major index.
REQ-008 SHALL have port out_block, output, ML*64, the natural-order block; element n occupies bits [n*ML+ML-1 : n*ML], with element 0 at the LSB.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1) forming the block handshake.

Function
REQ-010 SHALL accept a coefficient on each clk edge where in_valid && in_ready, with zigzag index k taken from a 6-bit write counter.
REQ-011 SHALL store sat(in_coef * qt[n]) at natural position n = ZZ[k], using the standard JPEG/MPEG zigzag order (ZZ[0..5] = 0,1,8,16,9,2).
REQ-012 SHALL form the product as signed ML × unsigned 8 → ML+8 bits, then saturate to [-2^(ML-1), 2^(ML-1)-1].
REQ-013 SHALL ping-pong two block buffers, each in state EMPTY, FILL or FULL; the write side moves EMPTY→FILL on the first accept.
REQ-014 SHALL move the write buffer FILL→FULL on the accept where k = 63, or where in_eob = 1; the counter then returns to 0 and the write side switches to the other buffer.
REQ-015 SHALL track a 64-bit written mask per buffer; out_block elements whose mask bit is 0 SHALL read as 0, so no explicit zero-fill cycles are needed.
REQ-016 SHALL register in_ready, driving it 1 iff the current write buffer is not FULL.
REQ-017 SHALL register out_valid, driving it 1 iff the read buffer is FULL, first asserting in the cycle after the completing accept edge (latency 1).
REQ-018 SHALL hold out_block stable while out_valid && !out_ready.
REQ-019 SHALL, on out_valid && out_ready, set the read buffer to EMPTY, clear its mask, and switch the read side to the other buffer.
REQ-020 SHALL process a simultaneous completing accept on one buffer and release of the other in the same cycle, with no lost or duplicated block.
REQ-021 SHALL sustain 64 accepts per 64 cycles when out_ready is held 1.
REQ-022 SHALL apply a quant table write to accepts in later cycles; an accept in the same cycle SHALL use the old entry.
REQ-023 SHALL ignore in_eob when in_valid && in_ready is 0.

Reset
REQ-024 SHALL, while rst = 1, put both buffers in EMPTY with masks cleared, the counter at 0, and the ping-pong pointers at buffer 0.
REQ-025 SHALL, while rst = 1, drive out_valid = 0 and in_ready = 1, and reset all quant table entries to 1.
REQ-026 SHALL discard a partially filled or unconsumed block when reset is asserted mid-operation; the first accept after reset is k = 0.

Structure
REQ-027 SHALL take the zigzag table ZZ[64], the default ML and the quant-entry width from shared package idct_pkg, which the IDCT block also uses.
REQ-028 SHALL place the multiply and saturate in one sub-module, dq_mul_sat (combinational, parameter ML).

Verification
REQ-029 SHALL check: qt all 1, stream coef k for k = 0..63 → elements 1 = 1, 8 = 2, 16 = 3, 63 = 63, and out_valid rises the cycle after the 64th accept.
REQ-030 SHALL check: qt[0] = 16, single coef 100 with in_eob → element 0 = 1600, other 63 elements = 0, out_valid the next cycle.
REQ-031 SHALL check saturation: coef 32767 with q = 2 → 32767; coef -300 with q = 255 → -32768.
REQ-032 SHALL check backpressure: out_ready = 0 with 3 blocks offered → in_ready falls after 128 accepts; raising out_ready → block 1, then block 2, then block 3, in order and intact.
REQ-033 SHALL check reset after 30 accepts → out_valid = 0, in_ready = 1, qt = 1, and the next coefficient lands at element 0.
REQ-034 SHALL check a qt_we to entry 0 in the same cycle as the k = 0 accept → the old scale is used, and the next block uses the new one.
